// File: rtl/axi_ts_trig_sel_if.sv
//==============================================================================
// Module      : axi_ts_trig_sel_if
// Description : Signal bundle between the trigger source conditioning stage
//               and its controller / consumers. The conditioning stage
//               connects through the slave modport. The driving side
//               connects through the master modport.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface axi_ts_trig_sel_if #(
    parameter int MISS_W = 16
) ();
    logic [7:0]        ext_trigger;
    logic              ctrl_arm_immediate;
    logic [31:0]       ctrl_arm_source;
    logic              ctrl_trigger_immediate;
    logic [31:0]       ctrl_trigger_source;
    logic [31:0]       ctrl_trigger_holdoff;
    logic [31:0]       ctrl_timer_period;
    logic              ctrl_clear;
    logic [31:0]       rtc_sec;
    logic [31:0]       rtc_nsec;
    logic              arm_pulse;
    logic              trigger_pulse;
    logic              stat_holdoff_active;
    logic [MISS_W-1:0] stat_trigger_missed;
    logic [31:0]       trig_ts_sec;
    logic [31:0]       trig_ts_nsec;
    logic              trig_ts_valid;

    modport slave (
        input  ext_trigger, ctrl_arm_immediate, ctrl_arm_source,
               ctrl_trigger_immediate, ctrl_trigger_source,
               ctrl_trigger_holdoff, ctrl_timer_period, ctrl_clear,
               rtc_sec, rtc_nsec,
        output arm_pulse, trigger_pulse, stat_holdoff_active,
               stat_trigger_missed, trig_ts_sec, trig_ts_nsec, trig_ts_valid
    );

    modport master (
        output ext_trigger, ctrl_arm_immediate, ctrl_arm_source,
               ctrl_trigger_immediate, ctrl_trigger_source,
               ctrl_trigger_holdoff, ctrl_timer_period, ctrl_clear,
               rtc_sec, rtc_nsec,
        input  arm_pulse, trigger_pulse, stat_holdoff_active,
               stat_trigger_missed, trig_ts_sec, trig_ts_nsec, trig_ts_valid
    );
endinterface

`default_nettype wire

// File: rtl/axi_ts_trig_sel.sv
//==============================================================================
// Module      : axi_ts_trig_sel
// Description : Trigger source conditioning. Synchronises 8 external trigger
//               lines, selects arm/trigger sources with slope, provides a
//               periodic timer source, trigger holdoff and a saturating
//               missed-trigger counter.
//               Optional macro AXI_TS_TRIG_TIMESTAMP_EN adds RTC capture on
//               each issued trigger pulse.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module axi_ts_trig_sel #(
    parameter int SYNC_STAGES = 2,
    parameter int MISS_W      = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    axi_ts_trig_sel_if.slave   bus
);

    // Edge detection is masked until the synchroniser and history flops
    // hold real line levels, so the post-reset reload never looks like an edge.
    localparam logic [2:0] c_SETTLE = 3'(SYNC_STAGES + 1);

    logic [7:0]        r_sync [SYNC_STAGES];
    logic [7:0]        r_hist;
    logic [2:0]        r_settle;
    logic              r_arm_imm_q;
    logic              r_trig_imm_q;
    logic [31:0]       r_trig_src_q;
    logic [31:0]       r_tmr_cnt;
    logic              r_tmr_run;
    logic [31:0]       r_hold;
    logic [MISS_W-1:0] r_missed;
    logic              r_arm_pulse;
    logic              r_trig_pulse;

    logic [7:0]        w_sync;
    logic [7:0]        w_rise;
    logic [7:0]        w_fall;
    logic              w_tick;
    logic              w_src_change;
    logic              w_arm_evt;
    logic              w_trig_evt;
    logic              w_trig_issue;
    logic              w_trig_miss;

    // Source decode: 1..8 pick an external line with slope, 9 is the timer.
    function automatic logic f_src_evt(input logic [31:0] cfg,
                                       input logic [7:0]  rise,
                                       input logic [7:0]  fall,
                                       input logic        tick);
        logic [3:0] idx;
        logic       evt;
        evt = 1'b0;
        idx = cfg[3:0] - 4'd1;
        if (cfg[3:0] >= 4'd1 && cfg[3:0] <= 4'd8) begin
            evt = cfg[4] ? fall[idx[2:0]] : rise[idx[2:0]];
        end else if (cfg[3:0] == 4'd9) begin
            evt = tick;
        end
        return evt;
    endfunction

    // Synchroniser chain, edge history and post-reset settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 8'h00;
            end
            r_hist   <= 8'h00;
            r_settle <= 3'd0;
        end else begin
            r_sync[0] <= bus.ext_trigger;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_hist <= w_sync;
            if (r_settle != c_SETTLE) begin
                r_settle <= r_settle + 3'd1;
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = (r_settle == c_SETTLE) ? ( w_sync & ~r_hist) : 8'h00;
    assign w_fall = (r_settle == c_SETTLE) ? (~w_sync &  r_hist) : 8'h00;

    // Registered copies of the software strobes and the trigger source config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arm_imm_q  <= 1'b0;
            r_trig_imm_q <= 1'b0;
            r_trig_src_q <= 32'd0;
        end else begin
            r_arm_imm_q  <= bus.ctrl_arm_immediate;
            r_trig_imm_q <= bus.ctrl_trigger_immediate;
            r_trig_src_q <= bus.ctrl_trigger_source;
        end
    end

    // Periodic timer: first tick PERIOD cycles after enable, then every PERIOD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr_cnt <= 32'd0;
            r_tmr_run <= 1'b0;
        end else if (bus.ctrl_timer_period == 32'd0) begin
            r_tmr_cnt <= 32'd0;
            r_tmr_run <= 1'b0;
        end else if (!r_tmr_run || r_tmr_cnt == 32'd0) begin
            r_tmr_cnt <= bus.ctrl_timer_period - 32'd1;
            r_tmr_run <= 1'b1;
        end else begin
            r_tmr_cnt <= r_tmr_cnt - 32'd1;
        end
    end

    assign w_tick = r_tmr_run && (bus.ctrl_timer_period != 32'd0) &&
                    (r_tmr_cnt == 32'd0);

    // Event combine: immediate strobe edge OR the selected source event.
    assign w_src_change = (bus.ctrl_trigger_source != r_trig_src_q);
    assign w_arm_evt    = (bus.ctrl_arm_immediate & ~r_arm_imm_q) |
                          f_src_evt(bus.ctrl_arm_source, w_rise, w_fall, w_tick);
    assign w_trig_evt   = ~w_src_change &
                          ((bus.ctrl_trigger_immediate & ~r_trig_imm_q) |
                           f_src_evt(bus.ctrl_trigger_source, w_rise, w_fall, w_tick));
    assign w_trig_issue = w_trig_evt && (r_hold == 32'd0);
    assign w_trig_miss  = w_trig_evt && (r_hold != 32'd0);

    // Holdoff window: a source change cancels it, an issued pulse reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= 32'd0;
        end else if (w_src_change) begin
            r_hold <= 32'd0;
        end else if (w_trig_issue) begin
            r_hold <= bus.ctrl_trigger_holdoff;
        end else if (r_hold != 32'd0) begin
            r_hold <= r_hold - 32'd1;
        end
    end

    // Saturating missed-trigger counter; clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_missed <= '0;
        end else if (bus.ctrl_clear) begin
            r_missed <= '0;
        end else if (w_trig_miss && (r_missed != {MISS_W{1'b1}})) begin
            r_missed <= r_missed + MISS_W'(1);
        end
    end

    // Registered single-cycle output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arm_pulse  <= 1'b0;
            r_trig_pulse <= 1'b0;
        end else begin
            r_arm_pulse  <= w_arm_evt;
            r_trig_pulse <= w_trig_issue;
        end
    end

    assign bus.arm_pulse           = r_arm_pulse;
    assign bus.trigger_pulse       = r_trig_pulse;
    assign bus.stat_holdoff_active = (r_hold != 32'd0);
    assign bus.stat_trigger_missed = r_missed;

`ifdef AXI_TS_TRIG_TIMESTAMP_EN
    logic [31:0] r_ts_sec;
    logic [31:0] r_ts_nsec;
    logic        r_ts_valid;

    // Capture the RTC in the cycle the trigger event is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts_sec   <= 32'd0;
            r_ts_nsec  <= 32'd0;
            r_ts_valid <= 1'b0;
        end else begin
            r_ts_valid <= w_trig_issue;
            if (w_trig_issue) begin
                r_ts_sec  <= bus.rtc_sec;
                r_ts_nsec <= bus.rtc_nsec;
            end
        end
    end

    assign bus.trig_ts_sec   = r_ts_sec;
    assign bus.trig_ts_nsec  = r_ts_nsec;
    assign bus.trig_ts_valid = r_ts_valid;
`else
    logic w_unused_rtc;
    assign w_unused_rtc      = ^{bus.rtc_sec, bus.rtc_nsec};
    assign bus.trig_ts_sec   = 32'd0;
    assign bus.trig_ts_nsec  = 32'd0;
    assign bus.trig_ts_valid = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_ts_trig_sel.sv
//==============================================================================
// Module      : tb_axi_ts_trig_sel
// Description : Self-checking bench for axi_ts_trig_sel (table of source /
//               slope vectors plus directed multi-cycle sequences).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_axi_ts_trig_sel;

    localparam int MISS_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi_ts_trig_sel_if #(.MISS_W(MISS_W)) bus ();

    axi_ts_trig_sel #(.SYNC_STAGES(2), .MISS_W(MISS_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] trig_src;
        logic [7:0] arm_src;
        logic [7:0] ext_a;
        logic [7:0] ext_b;
        int         exp_arm;
        int         exp_trig;
    } vec_t;

    vec_t vecs [9];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        step_no++;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int na, nt, base, ha_first;
        int pt[$];

        vecs[0] = '{8'h04, 8'h00, 8'h00, 8'h08, 0, 1};
        vecs[1] = '{8'h00, 8'h11, 8'h01, 8'h00, 1, 0};
        vecs[2] = '{8'h00, 8'h11, 8'h00, 8'h01, 0, 0};
        vecs[3] = '{8'h02, 8'h02, 8'h00, 8'h02, 1, 1};
        vecs[4] = '{8'h0A, 8'h0A, 8'h00, 8'hFF, 0, 0};
        vecs[5] = '{8'h18, 8'h00, 8'h80, 8'h00, 0, 1};
        vecs[6] = '{8'h08, 8'h01, 8'h7F, 8'hFF, 0, 1};
        vecs[7] = '{8'h00, 8'h00, 8'hFF, 8'h00, 0, 0};
        vecs[8] = '{8'h11, 8'h14, 8'h09, 8'h01, 1, 0};

        bus.ext_trigger            = 8'h00;
        bus.ctrl_arm_immediate     = 1'b0;
        bus.ctrl_arm_source        = 32'd0;
        bus.ctrl_trigger_immediate = 1'b0;
        bus.ctrl_trigger_source    = 32'd0;
        bus.ctrl_trigger_holdoff   = 32'd0;
        bus.ctrl_timer_period      = 32'd0;
        bus.ctrl_clear             = 1'b0;
        bus.rtc_sec                = 32'd0;
        bus.rtc_nsec               = 32'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arm",     bus.arm_pulse, 0);
        check("rst_trig",    bus.trigger_pulse, 0);
        check("rst_holdoff", bus.stat_holdoff_active, 0);
        check("rst_missed",  bus.stat_trigger_missed, 0);
        check("rst_ts",      {bus.trig_ts_valid, bus.trig_ts_sec, bus.trig_ts_nsec}, 0);
        rst_n = 1'b1;
        repeat (5) step();

        // Table: source select / slope vectors, counting pulses per window.
        for (int i = 0; i < 9; i++) begin
            bus.ctrl_trigger_source = {24'd0, vecs[i].trig_src};
            bus.ctrl_arm_source     = {24'd0, vecs[i].arm_src};
            bus.ext_trigger         = vecs[i].ext_a;
            repeat (8) step();
            bus.ext_trigger = vecs[i].ext_b;
            na = 0;
            nt = 0;
            repeat (8) begin
                step();
                na += int'(bus.arm_pulse);
                nt += int'(bus.trigger_pulse);
            end
            check($sformatf("vec%0d_arm", i),  na, vecs[i].exp_arm);
            check($sformatf("vec%0d_trig", i), nt, vecs[i].exp_trig);
        end

        // Latency: ext[3] rise -> pulse on the 3rd edge counting the sampling edge.
        bus.ctrl_trigger_source = 32'h04;
        bus.ctrl_arm_source     = 32'h00;
        bus.ext_trigger         = 8'h00;
        repeat (8) step();
        bus.ext_trigger = 8'h08;
        step(); check("lat_edge1", bus.trigger_pulse, 0);
        step(); check("lat_edge2", bus.trigger_pulse, 0);
        step(); check("lat_edge3", bus.trigger_pulse, 1);
        check("lat_arm", bus.arm_pulse, 0);
        step(); check("lat_edge4", bus.trigger_pulse, 0);

        // Timer source, period 5, then disabled.
        bus.ctrl_trigger_source = 32'h09;
        bus.ctrl_timer_period   = 32'd5;
        base = step_no;
        pt.delete();
        repeat (30) begin
            step();
            if (bus.trigger_pulse) pt.push_back(step_no - base);
        end
        bus.ctrl_timer_period = 32'd0;
        check("tmr_count", pt.size(), 5);
        if (pt.size() > 0) check("tmr_first", pt[0], 6);
        for (int k = 1; k < pt.size(); k++) check($sformatf("tmr_gap%0d", k), pt[k] - pt[k-1], 5);
        repeat (4) step();
        nt = 0;
        repeat (20) begin
            step();
            nt += int'(bus.trigger_pulse);
        end
        check("tmr_off", nt, 0);

        // Holdoff 10 with rising edges every 4 cycles.
        bus.ctrl_trigger_source  = 32'h02;
        bus.ctrl_trigger_holdoff = 32'd10;
        bus.ext_trigger          = 8'h00;
        repeat (12) step();
        pt.delete();
        ha_first = -1;
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < 4; s++) begin
                if (r < 4) bus.ext_trigger = (s < 2) ? 8'h02 : 8'h00;
                step();
                if (bus.trigger_pulse) begin
                    if (pt.size() == 0) ha_first = int'(bus.stat_holdoff_active);
                    pt.push_back(step_no);
                end
            end
        end
        check("hold_pulses", pt.size(), 2);
        if (pt.size() == 2) check("hold_gap", pt[1] - pt[0], 12);
        check("hold_active", ha_first, 1);
        check("hold_missed", bus.stat_trigger_missed, 2);
        bus.ctrl_clear = 1'b1;
        step();
        bus.ctrl_clear = 1'b0;
        check("hold_clear", bus.stat_trigger_missed, 0);
        repeat (12) step();
        check("hold_expired", bus.stat_holdoff_active, 0);

        // Saturation of the 4-bit missed counter.
        bus.ctrl_trigger_holdoff   = 32'd1000;
        bus.ctrl_trigger_immediate = 1'b1;
        step();
        check("sat_first", bus.trigger_pulse, 1);
        bus.ctrl_trigger_immediate = 1'b0;
        step();
        repeat (20) begin
            bus.ctrl_trigger_immediate = 1'b1;
            step();
            bus.ctrl_trigger_immediate = 1'b0;
            step();
        end
        check("sat_missed", bus.stat_trigger_missed, 15);
        check("sat_holdoff", bus.stat_holdoff_active, 1);

        // Asynchronous reset mid-holdoff with lines held high.
        bus.ctrl_arm_source = 32'h02;
        bus.ext_trigger     = 8'hFF;
        repeat (6) step();
        check("pre_rst_holdoff", bus.stat_holdoff_active, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs",
              {bus.arm_pulse, bus.trigger_pulse, bus.stat_holdoff_active, bus.trig_ts_valid}, 0);
        check("mid_rst_missed", bus.stat_trigger_missed, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        na = 0;
        nt = 0;
        repeat (12) begin
            step();
            na += int'(bus.arm_pulse);
            nt += int'(bus.trigger_pulse);
        end
        check("post_rst_arm", na, 0);
        check("post_rst_trig", nt, 0);

        // Immediate trigger with RTC capture.
        bus.ctrl_trigger_holdoff   = 32'd0;
        bus.rtc_sec                = 32'd7;
        bus.rtc_nsec               = 32'd123;
        bus.ctrl_trigger_immediate = 1'b1;
        step();
        bus.ctrl_trigger_immediate = 1'b0;
        bus.rtc_sec                = 32'd99;
        bus.rtc_nsec               = 32'd456;
        check("ts_trig", bus.trigger_pulse, 1);
`ifdef AXI_TS_TRIG_TIMESTAMP_EN
        check("ts_valid", bus.trig_ts_valid, 1);
        check("ts_sec",   bus.trig_ts_sec, 7);
        check("ts_nsec",  bus.trig_ts_nsec, 123);
`else
        check("ts_valid", bus.trig_ts_valid, 0);
        check("ts_value", {bus.trig_ts_sec, bus.trig_ts_nsec}, 0);
`endif
        step();
        check("ts_trig_end", bus.trigger_pulse, 0);
        check("ts_valid_end", bus.trig_ts_valid, 0);
`ifdef AXI_TS_TRIG_TIMESTAMP_EN
        check("ts_hold", {bus.trig_ts_sec, bus.trig_ts_nsec}, {32'd7, 32'd123});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
